// File: rtl/core_s2_mem_ctrl_if.sv
// Data-cache request/response channel between the stage-2 memory controller
// (master) and the data cache (slave).
interface core_s2_mem_ctrl_if;
    logic        dcache_req_valid;
    logic        dcache_req_ready;
    logic [31:0] dcache_req_addr;
    logic        dcache_req_we;
    logic [3:0]  dcache_req_wmask;
    logic [31:0] dcache_req_wdata;
    logic        dcache_rsp_valid;
    logic [31:0] dcache_rsp_data;

    modport master (
        output dcache_req_valid,
        output dcache_req_addr,
        output dcache_req_we,
        output dcache_req_wmask,
        output dcache_req_wdata,
        input  dcache_req_ready,
        input  dcache_rsp_valid,
        input  dcache_rsp_data
    );

    modport slave (
        input  dcache_req_valid,
        input  dcache_req_addr,
        input  dcache_req_we,
        input  dcache_req_wmask,
        input  dcache_req_wdata,
        output dcache_req_ready,
        output dcache_rsp_valid,
        output dcache_rsp_data
    );
endinterface

// File: rtl/core_s2_mem_ctrl.sv
// Stage-2 load/store controller: issues one data-cache access at a time,
// stalls the pipeline while it is in flight and extends load results.
module core_s2_mem_ctrl (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s2_valid,
    input  logic [1:0]                mem_op,
    input  logic [1:0]                mem_size,
    input  logic                      mem_unsigned,
    input  logic [31:0]               mem_addr,
    input  logic [31:0]               mem_wdata,
    input  logic                      flush,
    core_s2_mem_ctrl_if.master        dcache,
    output logic                      stall,
    output logic                      done,
    output logic [31:0]               load_data,
    output logic                      misaligned
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg;
    logic        we_reg;
    logic [3:0]  wmask_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  size_reg;
    logic        unsigned_reg;
    logic [31:0] load_data_reg;

    logic        is_mem;
    logic        addr_bad;
    logic        start;
    logic        capture_load;
    logic [1:0]  size_eff;
    logic [3:0]  wmask_in;
    logic [31:0] wdata_in;
    logic [31:0] rsp_shift;
    logic [31:0] load_ext;

    // Size 3 behaves as a word access everywhere, so normalise it once here.
    assign size_eff   = (mem_size == 2'd3) ? 2'd2 : mem_size;
    assign is_mem     = s2_valid && (mem_op == 2'd1 || mem_op == 2'd2) && !flush;
    assign addr_bad   = (size_eff == 2'd1 && mem_addr[0]) ||
                        (size_eff == 2'd2 && mem_addr[1:0] != 2'b00);
    assign misaligned = (state_reg == IDLE) && is_mem && addr_bad;
    assign start      = (state_reg == IDLE) && is_mem && !addr_bad;

    always_comb begin
        wmask_in = 4'b1111;
        wdata_in = mem_wdata;
        case (size_eff)
            2'd0: begin
                wmask_in = 4'b0001 << mem_addr[1:0];
                wdata_in = {4{mem_wdata[7:0]}};
            end
            2'd1: begin
                wmask_in = 4'b0011 << {mem_addr[1], 1'b0};
                wdata_in = {2{mem_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign rsp_shift = dcache.dcache_rsp_data >> {addr_reg[1:0], 3'b000};

    always_comb begin
        load_ext = rsp_shift;
        case (size_reg)
            2'd0: load_ext = {{24{!unsigned_reg && rsp_shift[7]}}, rsp_shift[7:0]};
            2'd1: load_ext = {{16{!unsigned_reg && rsp_shift[15]}}, rsp_shift[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next              = state_reg;
        dcache.dcache_req_valid = 1'b0;
        stall                   = 1'b0;
        done                    = 1'b0;
        capture_load            = 1'b0;
        case (state_reg)
            IDLE: begin
                stall = start;
                if (start) state_next = REQ;
            end
            REQ: begin
                dcache.dcache_req_valid = 1'b1;
                stall                   = 1'b1;
                if (dcache.dcache_req_ready) state_next = flush ? DRAIN : WAIT;
                else if (flush)              state_next = IDLE;
            end
            WAIT: begin
                stall = 1'b1;
                if (dcache.dcache_rsp_valid) begin
                    state_next   = flush ? IDLE : DONE;
                    capture_load = !flush;
                end else if (flush) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                stall = 1'b1;
                if (dcache.dcache_rsp_valid) state_next = IDLE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_reg      <= '0;
            we_reg        <= 1'b0;
            wmask_reg     <= '0;
            wdata_reg     <= '0;
            size_reg      <= '0;
            unsigned_reg  <= 1'b0;
            load_data_reg <= '0;
        end else begin
            if (start) begin
                addr_reg     <= mem_addr;
                we_reg       <= (mem_op == 2'd2);
                wmask_reg    <= wmask_in;
                wdata_reg    <= wdata_in;
                size_reg     <= size_eff;
                unsigned_reg <= mem_unsigned;
            end
            // Stores complete with a zero result so writeback never sees stale data.
            if (capture_load) load_data_reg <= we_reg ? 32'd0 : load_ext;
        end
    end

    assign dcache.dcache_req_addr  = {addr_reg[31:2], 2'b00};
    assign dcache.dcache_req_we    = we_reg;
    assign dcache.dcache_req_wmask = wmask_reg;
    assign dcache.dcache_req_wdata = wdata_reg;
    assign load_data               = load_data_reg;
endmodule

// File: tb/tb_core_s2_mem_ctrl.sv
// Randomised and directed bench for core_s2_mem_ctrl against a byte-lane
// reference model of the load/store rules.
module tb_core_s2_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        s2_valid;
    logic [1:0]  mem_op;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        misaligned;

    int n_tests = 0;
    int n_fail  = 0;

    core_s2_mem_ctrl_if dif ();

    core_s2_mem_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s2_valid     (s2_valid),
        .mem_op       (mem_op),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .flush        (flush),
        .dcache       (dif),
        .stall        (stall),
        .done         (done),
        .load_data    (load_data),
        .misaligned   (misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access width in bytes, then lane arithmetic.
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_wmask(input logic [1:0] sz, input logic [31:0] a);
        int m;
        m = ((1 << nbytes(sz)) - 1) << int'(a[1:0]);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        int n;
        n = nbytes(sz);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rsp);
        logic [63:0] w, mask, v;
        int n;
        n    = nbytes(sz);
        w    = {32'd0, rsp} >> (8 * int'(a[1:0]));
        mask = (64'd1 << (8 * n)) - 64'd1;
        v    = w & mask;
        if (!uns && n < 4 && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic do_access(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rsp, input int rdly, input int sdly);
        logic       is_mem, is_store, exp_mis;
        logic [1:0] szn;
        int         cyc;
        is_mem   = (op == 2'd1) || (op == 2'd2);
        is_store = (op == 2'd2);
        szn      = (sz == 2'd3) ? 2'd2 : sz;
        exp_mis  = is_mem && m_mis(szn, addr);
        step();
        s2_valid = 1'b1; mem_op = op; mem_size = sz; mem_unsigned = uns;
        mem_addr = addr; mem_wdata = wd; flush = 1'b0;
        @(negedge clk);
        chk("misaligned", misaligned, exp_mis);
        chk("start_stall", stall, is_mem && !exp_mis);
        if (!is_mem || exp_mis) begin
            step();
            s2_valid = 1'b0;
            @(negedge clk);
            chk("noreq_valid", dif.dcache_req_valid, 1'b0);
            chk("noreq_stall", stall, 1'b0);
            return;
        end
        step();
        // Scramble inputs: the request must come from latched values.
        s2_valid = 1'b0; mem_addr = $urandom; mem_wdata = $urandom; mem_size = 2'($urandom);
        cyc = 1;
        for (int i = 0; i <= rdly; i++) begin
            dif.dcache_req_ready = (i == rdly);
            dif.dcache_rsp_valid = 1'($urandom);
            dif.dcache_rsp_data  = $urandom;
            @(negedge clk);
            chk("req_valid", dif.dcache_req_valid, 1'b1);
            chk("req_addr", dif.dcache_req_addr, {addr[31:2], 2'b00});
            chk("req_we", dif.dcache_req_we, is_store);
            chk("req_wmask", dif.dcache_req_wmask, m_wmask(szn, addr));
            chk("req_wdata", dif.dcache_req_wdata, m_wdata(szn, wd));
            chk("req_stall", stall, 1'b1);
            step();
            cyc++;
        end
        dif.dcache_req_ready = 1'b0;
        for (int j = 0; j <= sdly; j++) begin
            dif.dcache_rsp_valid = (j == sdly);
            dif.dcache_rsp_data  = (j == sdly) ? rsp : $urandom;
            @(negedge clk);
            chk("wait_valid", dif.dcache_req_valid, 1'b0);
            chk("wait_stall", stall, 1'b1);
            chk("wait_done", done, 1'b0);
            step();
            cyc++;
        end
        dif.dcache_rsp_valid = 1'b0;
        @(negedge clk);
        chk("done", done, 1'b1);
        chk("done_latency", cyc, 3 + rdly + sdly);
        chk("load_data", load_data, is_store ? 32'd0 : m_load(szn, uns, addr, rsp));
        chk("done_stall", stall, 1'b0);
        step();
        dif.dcache_rsp_valid = 1'($urandom);
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
        chk("idle_valid", dif.dcache_req_valid, 1'b0);
        dif.dcache_rsp_valid = 1'b0;
    endtask

    task automatic begin_lw(input logic [31:0] addr);
        step();
        s2_valid = 1'b1; mem_op = 2'd1; mem_size = 2'd2; mem_addr = addr;
        step();
        s2_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; s2_valid = 1'b0; mem_op = 2'd0; mem_size = 2'd0; mem_unsigned = 1'b0;
        mem_addr = '0; mem_wdata = '0; flush = 1'b0;
        dif.dcache_req_ready = 1'b0; dif.dcache_rsp_valid = 1'b0; dif.dcache_rsp_data = '0;
        step();
        step();
        @(negedge clk);
        chk("rst_valid", dif.dcache_req_valid, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_load", load_data, 32'd0);
        chk("rst_wmask", dif.dcache_req_wmask, 4'd0);
        chk("rst_addr", dif.dcache_req_addr, 32'd0);
        chk("rst_wdata", dif.dcache_req_wdata, 32'd0);
        chk("rst_we", dif.dcache_req_we, 1'b0);
        step();
        rst_n = 1'b1;

        do_access(2'd1, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80FFFFFF, 0, 0);
        do_access(2'd1, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80FFFFFF, 0, 0);
        do_access(2'd2, 2'd1, 1'b0, 32'h2002, 32'h1234ABCD, 32'hDEADBEEF, 2, 0);
        do_access(2'd1, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h0, 0, 0);
        do_access(2'd1, 2'd1, 1'b0, 32'h3002, 32'h0, 32'h8001_7FFF, 1, 1);

        // Flush in WAIT, response four cycles later: drained silently.
        begin_lw(32'h4000);
        dif.dcache_req_ready = 1'b1;
        step();
        dif.dcache_req_ready = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("f_wait_stall", stall, 1'b1);
        step();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dif.dcache_rsp_valid = (i == 3);
            @(negedge clk);
            chk("drain_stall", stall, 1'b1);
            chk("drain_done", done, 1'b0);
            step();
        end
        dif.dcache_rsp_valid = 1'b0;
        @(negedge clk);
        chk("drain_idle_stall", stall, 1'b0);
        chk("drain_idle_done", done, 1'b0);

        // Flush in REQ with no ready: request withdrawn immediately.
        begin_lw(32'h5000);
        flush = 1'b1;
        @(negedge clk);
        chk("f_req_valid", dif.dcache_req_valid, 1'b1);
        step();
        flush = 1'b0; dif.dcache_req_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("f_req_gone", dif.dcache_req_valid, 1'b0);
            chk("f_req_stall", stall, 1'b0);
            step();
        end
        dif.dcache_req_ready = 1'b0;

        // Flush in REQ together with ready: accepted, so must drain.
        begin_lw(32'h5004);
        flush = 1'b1; dif.dcache_req_ready = 1'b1;
        step();
        flush = 1'b0; dif.dcache_req_ready = 1'b0;
        @(negedge clk);
        chk("f_rdy_stall", stall, 1'b1);
        chk("f_rdy_valid", dif.dcache_req_valid, 1'b0);
        dif.dcache_rsp_valid = 1'b1;
        step();
        dif.dcache_rsp_valid = 1'b0;
        @(negedge clk);
        chk("f_rdy_done", done, 1'b0);
        chk("f_rdy_idle", stall, 1'b0);

        // Flush in WAIT coinciding with the response: straight to IDLE, no done.
        begin_lw(32'h5008);
        dif.dcache_req_ready = 1'b1;
        step();
        dif.dcache_req_ready = 1'b0; flush = 1'b1; dif.dcache_rsp_valid = 1'b1;
        step();
        flush = 1'b0; dif.dcache_rsp_valid = 1'b0;
        @(negedge clk);
        chk("f_rsp_done", done, 1'b0);
        chk("f_rsp_stall", stall, 1'b0);

        // Reset while waiting; the late response must be ignored.
        begin_lw(32'h6000);
        dif.dcache_req_ready = 1'b1;
        step();
        dif.dcache_req_ready = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1; dif.dcache_rsp_valid = 1'b1; dif.dcache_rsp_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("wrst_stall", stall, 1'b0);
        chk("wrst_valid", dif.dcache_req_valid, 1'b0);
        chk("wrst_addr", dif.dcache_req_addr, 32'd0);
        chk("wrst_wmask", dif.dcache_req_wmask, 4'd0);
        step();
        dif.dcache_rsp_valid = 1'b0;
        @(negedge clk);
        chk("wrst_done", done, 1'b0);
        chk("wrst_load", load_data, 32'd0);

        for (int k = 0; k < 60; k++) begin
            do_access(2'($urandom), 2'($urandom), 1'($urandom),
                      (k % 3 == 0) ? {$urandom} & 32'hFFFF_FFFC : $urandom,
                      $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/core_s2_mem_ctrl.md
CORE_S2_MEM_CTRL -- requirements
Module: core_s2_mem_ctrl

Interface
REQ-001 clk  input  1  core clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset; synchronous, active-low.
REQ-003 s2_valid  input  1  stage 2 holds a valid instruction.
REQ-004 mem_op  input  2  operation: 0 NONE, 1 LOAD, 2 STORE; 3 is treated as NONE.
REQ-005 mem_size  input  2  access size: 0 byte, 1 half, 2 word; 3 is treated as word.
REQ-006 mem_unsigned  input  1  load result is zero-extended when 1, sign-extended when 0.
REQ-007 mem_addr  input  32  byte address, from alu_result.
REQ-008 mem_wdata  input  32  store data, from saved_rs2.
REQ-009 flush  input  1  kill the current stage 2 access.
REQ-010 dcache_req_valid  output  1  request valid.
REQ-011 dcache_req_ready  input  1  dcache accepts the request.
REQ-012 dcache_req_addr  output  32  word-aligned address, i.e. {addr[31:2],2'b00}.
REQ-013 dcache_req_we  output  1  1 for a store.
REQ-014 dcache_req_wmask  output  4  byte enables.
REQ-015 dcache_req_wdata  output  32  lane-replicated store data.
REQ-016 dcache_rsp_valid  input  1  response or store acknowledge, one cycle wide.
REQ-017 dcache_rsp_data  input  32  load word.
REQ-018 stall  output  1  hold stage 2 and upstream.
REQ-019 done  output  1  one-cycle pulse when the access completes.
REQ-020 load_data  output  32  extended load result, valid while done=1.
REQ-021 misaligned  output  1  address misaligned for mem_size; combinational.

Function
REQ-022 States SHALL be IDLE, REQ, WAIT, DRAIN and DONE.
REQ-023 start = s2_valid && mem_op is LOAD or STORE && !flush && !misaligned, evaluated in IDLE only.
REQ-024 misaligned SHALL be 1 only in IDLE with s2_valid, a memory op and no flush, and only for: half with addr[0]=1, or word with addr[1:0]!=0.
REQ-025 A misaligned access SHALL issue no request, assert no stall and leave the state in IDLE.
REQ-026 IDLE on start -> REQ; addr, we, wmask, wdata, size and unsigned SHALL be latched on the same edge.
REQ-027 wmask: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111.
REQ-028 wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
REQ-029 dcache_req_valid SHALL be 1 exactly while in REQ, driven from the latched values; request outputs SHALL stay stable until the handshake.
REQ-030 REQ: valid&&ready -> WAIT; flush without ready -> IDLE with no request issued; flush with ready -> DRAIN.
REQ-031 WAIT: rsp_valid -> DONE (load_data latched); flush without rsp_valid -> DRAIN; flush with rsp_valid -> IDLE with no done.
REQ-032 DRAIN: wait for rsp_valid, then -> IDLE; done SHALL NOT assert and the response SHALL be discarded.
REQ-033 DONE: done=1 for exactly 1 cycle, then -> IDLE; a new start SHALL NOT be accepted in DONE.
REQ-034 rsp_valid SHALL be ignored in IDLE, REQ and DONE.
REQ-035 Load extract: w = rsp_data >> (8*addr[1:0]); byte extends w[7:0], half extends w[15:0], word passes through unchanged.
REQ-036 For stores, load_data SHALL be 0 at done.
REQ-037 stall = (IDLE && start) || REQ || WAIT || DRAIN; stall=0 in DONE.
REQ-038 Minimum latency start->done SHALL be 3 cycles (ready in REQ, rsp_valid on the first WAIT cycle).
REQ-039 At most one request SHALL be outstanding at any time.

Reset
REQ-040 When rst_n=0 at an edge, from any state including mid-transaction, the FSM SHALL go to IDLE and all latched registers SHALL clear to 0.
REQ-041 Reset outputs: dcache_req_valid=0, stall=0, done=0, load_data=0, wmask=0, req_addr=0, req_wdata=0, req_we=0.
REQ-042 A response arriving after reset SHALL be ignored.

Verification
REQ-043 LB addr=0x1003, rsp_data=0x80FFFFFF, ready and rsp immediate -> req_addr=0x1000, done on cycle 3, load_data=0xFFFFFF80; with LBU -> 0x00000080.
REQ-044 SH addr=0x2002, wdata=0x1234ABCD, ready after 2 wait cycles -> wmask=4'b1100, wdata=0xABCDABCD, we=1, request stable during wait, load_data=0.
REQ-045 LW addr=0x3001 -> misaligned=1, stall=0, dcache_req_valid never 1; LH addr=0x3002 -> misaligned=0.
REQ-046 LW accepted, flush in WAIT, rsp 4 cycles later -> DRAIN, stall=1 until rsp, done never asserts, IDLE after.
REQ-047 Flush in REQ with ready=0 -> IDLE next cycle, no handshake ever occurs.
REQ-048 rst_n=0 in WAIT, then rsp_valid=1 -> IDLE, all outputs at reset values, done stays 0.
